// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the alu issue controller: opcodes, FSM states and
// instruction field positions.
package alu_issue_ctrl_pkg;

    localparam int unsigned InstrW  = 16;
    localparam int unsigned OpW     = 4;
    localparam int unsigned RegIdxW = 3;
    localparam int unsigned FlagW   = 4;

    localparam logic [OpW-1:0] OpNop  = 4'b0000;
    localparam logic [OpW-1:0] OpLdi  = 4'b0001;
    localparam logic [OpW-1:0] OpAdd  = 4'b0010;
    localparam logic [OpW-1:0] OpSub  = 4'b0011;
    localparam logic [OpW-1:0] OpAnd  = 4'b0100;
    localparam logic [OpW-1:0] OpOr   = 4'b0101;
    localparam logic [OpW-1:0] OpXor  = 4'b0110;
    localparam logic [OpW-1:0] OpNotA = 4'b0111;

    localparam int unsigned OpMsb  = 15;
    localparam int unsigned OpLsb  = 12;
    localparam int unsigned RdMsb  = 11;
    localparam int unsigned RdLsb  = 9;
    localparam int unsigned RaMsb  = 8;
    localparam int unsigned RaLsb  = 6;
    localparam int unsigned RbMsb  = 5;
    localparam int unsigned RbLsb  = 3;
    localparam int unsigned ImmMsb = 7;
    localparam int unsigned ImmLsb = 0;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StWb
    } state_e;

    // Opcodes that are executed by the external alu.
    function automatic logic is_alu_op(input logic [OpW-1:0] op);
        return (op >= OpAdd) && (op <= OpNotA);
    endfunction

    // Upper half of the opcode space is reserved.
    function automatic logic is_illegal_op(input logic [OpW-1:0] op);
        return op[OpW-1];
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake, alu drive/return bus and status/debug signals of the
// issue controller. The slave side is the controller itself.
interface alu_issue_ctrl_if #(
    parameter int unsigned DataWidth = 8
) ();
    import alu_issue_ctrl_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [InstrW-1:0]    in_instr;

    logic                 alu_en;
    logic                 alu_oe;
    logic [OpW-1:0]       alu_opcode;
    logic [DataWidth-1:0] alu_a;
    logic [DataWidth-1:0] alu_b;
    logic [DataWidth-1:0] alu_out;
    logic                 alu_cf;
    logic                 alu_of;
    logic                 alu_sf;
    logic                 alu_zf;

    logic [FlagW-1:0]     flags;
    logic                 done;
    logic                 err;
    logic                 busy;
    logic [RegIdxW-1:0]   dbg_addr;
    logic [DataWidth-1:0] dbg_data;

    modport master (
        output in_valid, in_instr, alu_out, alu_cf, alu_of, alu_sf, alu_zf, dbg_addr,
        input  in_ready, alu_en, alu_oe, alu_opcode, alu_a, alu_b, flags, done, err, busy,
               dbg_data
    );

    modport slave (
        input  in_valid, in_instr, alu_out, alu_cf, alu_of, alu_sf, alu_zf, dbg_addr,
        output in_ready, alu_en, alu_oe, alu_opcode, alu_a, alu_b, flags, done, err, busy,
               dbg_data
    );

endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// NumRegs x DataWidth register file: two async operand reads, one async debug
// read, one synchronous write, synchronous clear.
module alu_issue_ctrl_regfile #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned NumRegs   = 8,
    parameter int unsigned IdxW      = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IdxW-1:0]      ra_addr_i,
    output logic [DataWidth-1:0] ra_data_o,
    input  logic [IdxW-1:0]      rb_addr_i,
    output logic [DataWidth-1:0] rb_data_o,
    input  logic [IdxW-1:0]      dbg_addr_i,
    output logic [DataWidth-1:0] dbg_data_o,
    input  logic                 we_i,
    input  logic [IdxW-1:0]      wr_addr_i,
    input  logic [DataWidth-1:0] wr_data_i
);

    logic [DataWidth-1:0] regs_q [NumRegs];

    // Clear on reset, otherwise single write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign ra_data_o  = regs_q[ra_addr_i];
    assign rb_data_o  = regs_q[rb_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the 8-bit alu: accepts instructions, executes LDI/NOP and
// illegal opcodes locally, sequences alu ops through ISSUE/WAIT/WB and writes
// the result and flags back.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned NumRegs   = 8,
    parameter int unsigned AluLat    = 1
) (
    input logic           clk,
    input logic           rst,
    alu_issue_ctrl_if.slave bus
);

    localparam int unsigned CntW     = (AluLat > 2) ? $clog2(AluLat) : 1;
    localparam int unsigned WaitInit = (AluLat >= 2) ? AluLat - 2 : 0;

    state_e               state;
    logic [CntW-1:0]      wait_cnt;
    logic [OpW-1:0]       op_q;
    logic [DataWidth-1:0] a_q;
    logic [DataWidth-1:0] b_q;
    logic [RegIdxW-1:0]   rd_q;
    logic                 en_q;
    logic [FlagW-1:0]     flags_q;
    logic                 done_q;
    logic                 err_q;

    logic [OpW-1:0]       in_op;
    logic [RegIdxW-1:0]   in_rd;
    logic [RegIdxW-1:0]   in_ra;
    logic [RegIdxW-1:0]   in_rb;
    logic [DataWidth-1:0] in_imm;
    logic                 accept;

    logic [DataWidth-1:0] rd_a;
    logic [DataWidth-1:0] rd_b;
    logic                 wr_en;
    logic [RegIdxW-1:0]   wr_addr;
    logic [DataWidth-1:0] wr_data;

    assign in_op  = bus.in_instr[OpMsb:OpLsb];
    assign in_rd  = bus.in_instr[RdMsb:RdLsb];
    assign in_ra  = bus.in_instr[RaMsb:RaLsb];
    assign in_rb  = bus.in_instr[RbMsb:RbLsb];
    assign in_imm = DataWidth'(bus.in_instr[ImmMsb:ImmLsb]);
    assign accept = bus.in_valid && (state == StIdle);

    // Operands are sampled on the accept edge, which is the same regfile state
    // the ISSUE cycle would see, so rd==ra/rb reads the old value.
    alu_issue_ctrl_regfile #(
        .DataWidth (DataWidth),
        .NumRegs   (NumRegs),
        .IdxW      (RegIdxW)
    ) u_regfile (
        .clk_i      (clk),
        .rst_i      (rst),
        .ra_addr_i  (in_ra),
        .ra_data_o  (rd_a),
        .rb_addr_i  (in_rb),
        .rb_data_o  (rd_b),
        .dbg_addr_i (bus.dbg_addr),
        .dbg_data_o (bus.dbg_data),
        .we_i       (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data)
    );

    // Write port: alu result on the edge ending WB, immediate on LDI accept.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = in_rd;
        wr_data = in_imm;
        if (state == StWb) begin
            wr_en   = 1'b1;
            wr_addr = rd_q;
            wr_data = bus.alu_out;
        end else if (accept && (in_op == OpLdi)) begin
            wr_en = 1'b1;
        end
    end

    // Sequencer with registered alu drives, flags, done pulse and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            wait_cnt <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_q     <= '0;
            en_q     <= 1'b0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        if (is_alu_op(in_op)) begin
                            state <= StIssue;
                            op_q  <= in_op;
                            a_q   <= rd_a;
                            b_q   <= rd_b;
                            rd_q  <= in_rd;
                            en_q  <= 1'b1;
                        end else begin
                            // LDI, NOP and illegal retire without leaving IDLE.
                            done_q <= 1'b1;
                            if (is_illegal_op(in_op)) begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                StIssue: begin
                    if (AluLat > 1) begin
                        state    <= StWait;
                        wait_cnt <= CntW'(WaitInit);
                    end else begin
                        state <= StWb;
                    end
                end
                StWait: begin
                    if (wait_cnt == '0) begin
                        state <= StWb;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StWb: begin
                    state   <= StIdle;
                    flags_q <= {bus.alu_cf, bus.alu_of, bus.alu_sf, bus.alu_zf};
                    done_q  <= 1'b1;
                    op_q    <= '0;
                    a_q     <= '0;
                    b_q     <= '0;
                    en_q    <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = (state == StIdle);
    assign bus.busy       = (state != StIdle);
    assign bus.alu_en     = en_q;
    assign bus.alu_oe     = en_q;
    assign bus.alu_opcode = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.flags      = flags_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule
